// File: rtl/atm_balance_arbiter_if.sv
// Terminal-to-arbiter bus for atm_balance_arbiter.
// Purpose: groups the request and response signals that the terminal
// front-ends share with the balance arbiter.
// Signals:
//   req         per-terminal request, held until done
//   opCode      packed 2-bit op per terminal (00 no-op, 01 view, 10 deposit, 11 withdraw)
//   acct        packed AW-bit account index per terminal
//   amount      packed BAL_W-bit amount per terminal
//   gnt         one-hot grant, high for the whole transaction
//   done        one-cycle completion pulse
//   status      00 OK, 01 insufficient funds, 10 overflow, 11 bad op/account
//   balance_out balance after the transaction, valid with done
//   busy        arbiter is not idle
// Modports: master = terminal side, slave = arbiter side.
interface atm_balance_arbiter_if #(
  parameter int NUM_TERM = 4,
  parameter int NUM_ACCT = 8,
  parameter int BAL_W    = 32
);
  localparam int AW = $clog2(NUM_ACCT);

  logic [NUM_TERM-1:0]       req;
  logic [2*NUM_TERM-1:0]     opCode;
  logic [AW*NUM_TERM-1:0]    acct;
  logic [BAL_W*NUM_TERM-1:0] amount;
  logic [NUM_TERM-1:0]       gnt;
  logic                      done;
  logic [1:0]                status;
  logic [BAL_W-1:0]          balance_out;
  logic                      busy;

  modport master (
    output req, opCode, acct, amount,
    input  gnt, done, status, balance_out, busy
  );

  modport slave (
    input  req, opCode, acct, amount,
    output gnt, done, status, balance_out, busy
  );
endinterface

// File: rtl/atm_balance_arbiter.sv
// atm_balance_arbiter
// Purpose: serialises view/deposit/withdraw transactions from NUM_TERM ATM
// terminals onto a single on-chip balance store. Round-robin arbitration,
// one read-modify-write per transaction, fixed 3-cycle latency from the
// arbitration edge to the done pulse.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset (reloads every account to INIT_BAL)
//   bus    atm_balance_arbiter_if.slave (req/opCode/acct/amount in,
//          gnt/done/status/balance_out/busy out)
module atm_balance_arbiter #(
  parameter int          NUM_TERM = 4,
  parameter int          NUM_ACCT = 8,
  parameter int          BAL_W    = 32,
  parameter int unsigned INIT_BAL = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  atm_balance_arbiter_if.slave bus
);
  localparam int AW = $clog2(NUM_ACCT);
  localparam int IW = $clog2(NUM_TERM);

  localparam logic [1:0] OP_VIEW     = 2'b01;
  localparam logic [1:0] OP_DEPOSIT  = 2'b10;
  localparam logic [1:0] OP_WITHDRAW = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_NOFUNDS  = 2'b01;
  localparam logic [1:0] ST_OVERFLOW = 2'b10;
  localparam logic [1:0] ST_BAD      = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

  state_t           state;
  logic [IW-1:0]    last_grant;
  logic [BAL_W-1:0] bal_mem [NUM_ACCT];

  logic [IW-1:0]    win_p0;
  logic [1:0]       op_p0;
  logic [AW-1:0]    acct_p0;
  logic [BAL_W-1:0] amt_p0;
  logic [BAL_W-1:0] bal_p1;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand;
  logic             acct_ok;
  logic [BAL_W:0]   dep_sum;

  // Deposit sum carried one bit wide so the carry flags overflow.
  function automatic logic [BAL_W:0] add_wide(input logic [BAL_W-1:0] a,
                                              input logic [BAL_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic withdraw_ok(input logic [BAL_W-1:0] bal,
                                       input logic [BAL_W-1:0] amt);
    return amt <= bal;
  endfunction

  // Round-robin search begins one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_TERM; i++) begin
      cand = IW'((int'(last_grant) + i) % NUM_TERM);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign acct_ok  = ({1'b0, acct_p0} < (AW+1)'(NUM_ACCT));
  assign dep_sum  = add_wide(bal_p1, amt_p0);
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      bus.gnt         <= '0;
      bus.done        <= 1'b0;
      bus.status      <= ST_OK;
      bus.balance_out <= '0;
      last_grant      <= IW'(NUM_TERM - 1);
      for (int i = 0; i < NUM_ACCT; i++) bal_mem[i] <= BAL_W'(INIT_BAL);
    end else begin
      case (state)
        // IDLE: arbitrate and latch the winner's request
        IDLE: begin
          if (win_found) begin
            win_p0  <= win_idx;
            op_p0   <= bus.opCode[int'(win_idx)*2 +: 2];
            acct_p0 <= bus.acct[int'(win_idx)*AW +: AW];
            amt_p0  <= bus.amount[int'(win_idx)*BAL_W +: BAL_W];
            bus.gnt <= NUM_TERM'(1) << win_idx;
            state   <= READ;
          end
        end
        // READ: fetch the current balance
        READ: begin
          bal_p1 <= acct_ok ? bal_mem[acct_p0] : '0;
          state  <= EXEC;
        end
        // EXEC: evaluate the op, write back, register the response
        EXEC: begin
          bus.done        <= 1'b1;
          bus.balance_out <= bal_p1;
          state           <= RESP;
          if (!acct_ok) begin
            bus.status <= ST_BAD;
          end else begin
            case (op_p0)
              OP_VIEW: bus.status <= ST_OK;
              OP_DEPOSIT: begin
                if (dep_sum[BAL_W]) begin
                  bus.status <= ST_OVERFLOW;
                end else begin
                  bus.status      <= ST_OK;
                  bus.balance_out <= dep_sum[BAL_W-1:0];
                  bal_mem[acct_p0] <= dep_sum[BAL_W-1:0];
                end
              end
              OP_WITHDRAW: begin
                if (!withdraw_ok(bal_p1, amt_p0)) begin
                  bus.status <= ST_NOFUNDS;
                end else begin
                  bus.status      <= ST_OK;
                  bus.balance_out <= bal_p1 - amt_p0;
                  bal_mem[acct_p0] <= bal_p1 - amt_p0;
                end
              end
              default: bus.status <= ST_BAD;
            endcase
          end
        end
        // RESP: done is high this cycle; release grant and advance priority
        RESP: begin
          bus.done   <= 1'b0;
          bus.gnt    <= '0;
          last_grant <= win_p0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/atm_balance_arbiter.md
# atm_balance_arbiter

Shared-account controller that serialises balance transactions (view, deposit, withdraw) from several ATM terminal front-ends onto one on-chip balance store. Each terminal FSM raises a request with its opCode, account index and amount. The arbiter grants terminals round-robin, executes one read-modify-write per transaction and returns a status and the resulting balance. It sits between the per-terminal ATM FSMs and the account balance registers, and is the only writer of those registers.

## Interface
- NUM_TERM, 4, number of requesting terminals (2..8)
- NUM_ACCT, 8, number of accounts in the store
- BAL_W, 32, balance/amount width, unsigned
- INIT_BAL, 1000, balance loaded into every account at reset
- AW, $clog2(NUM_ACCT), account index width (derived, not overridden)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- req  input  NUM_TERM  per-terminal request, held high until its done
- opCode  input  2*NUM_TERM  packed per terminal: 00 no-op, 01 view, 10 deposit, 11 withdraw
- acct  input  AW*NUM_TERM  packed per-terminal account index
- amount  input  BAL_W*NUM_TERM  packed per-terminal amount
- gnt  output  NUM_TERM  one-hot grant, high for the whole transaction
- done  output  1  one-cycle completion pulse for the granted terminal
- status  output  2  00 OK, 01 insufficient funds, 10 overflow, 11 bad op/account; valid with done
- balance_out  output  BAL_W  account balance after the transaction; valid with done
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, READ, EXEC, RESP.
- IDLE
  - If any req is high, pick the winner round-robin: search starts at (last_grant+1) mod NUM_TERM.
  - Latch winner index, opCode, acct and amount; set gnt one-hot; go to READ.
  - If no req is high, stay in IDLE with gnt=0.
- READ: read the balance of the latched account into a holding register; go to EXEC.
- EXEC: evaluate the latched op, then go to RESP.
  - acct ≥ NUM_ACCT or op 00: status 11, no write.
  - view (01): status 00, no write.
  - deposit (10): compute the sum at BAL_W+1 bits. Carry out gives status 10 and no write; otherwise write the sum, status 00.
  - withdraw (11): amount > balance gives status 01 and no write; otherwise write balance−amount, status 00. Amount equal to balance is allowed and leaves 0.
  - Amount 0 is legal for deposit and withdraw: status 00, balance unchanged.
- RESP
  - done=1; status and balance_out valid. balance_out is the post-write value, or the unchanged value on error.
  - gnt stays high this cycle. last_grant is updated to the winner.
  - Go to IDLE.
- Inputs are sampled only in the IDLE arbitration cycle. Changes to opCode, acct or amount mid-transaction are ignored.
- A terminal drops req after seeing done. If req is still high in the following IDLE cycle, it is treated as a new request. Round-robin prevents starvation.
- Two terminals on the same account are serialised; the second sees the first's write.

## Timing
- Arbitration edge k (IDLE, req sampled) leads to gnt high from cycle k+1 through k+3, and done high in cycle k+3 only.
- Fixed latency: 3 cycles from the sampling edge to done. Throughput: one transaction per 4 cycles.
- The balance write occurs at the EXEC→RESP edge. The new value is visible to a READ in the next transaction.
- Reset (reset=0 at a rising edge) dominates every state:
  - state=IDLE, gnt=0, done=0, status=00, balance_out=0, busy=0.
  - last_grant=NUM_TERM−1, so terminal 0 has first priority.
  - All accounts are reloaded to INIT_BAL.
- A reset during READ, EXEC or RESP aborts the transaction with no done pulse. Any partial write is overwritten by INIT_BAL.
- done, gnt, status and balance_out are registered outputs, with no combinational path from inputs.

## Test plan
- Single withdraw: after reset, terminal 0 sends op 11, acct 2, amount 0x40.
  - Required: gnt=0001 for 3 cycles; done at +3; status 00; balance_out 936. A following view of acct 2 returns 936.
- Insufficient funds: terminal 1 sends op 11, acct 0, amount 1001 → status 01, balance_out 1000, account unchanged.
- Deposit overflow: deposit 0xFFFFFFFF to acct 3 → status 10, balance stays 1000. A deposit of 0x40 then gives 1064, status 00.
- Round-robin: all four terminals request views simultaneously and hold req → grant order 0,1,2,3,0. Each done is 4 cycles apart.
- Bad input: op 00 → status 11. acct ≥ NUM_ACCT (with NUM_ACCT=6, acct 7) → status 11. No account changes in either case.
- Reset mid-op: assert reset during EXEC of a withdraw 0x40 on acct 5.
  - Required: no done pulse; all outputs 0. After release, a view of acct 5 returns 1000.
